// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: controller states,
// default geometry and the packed-port slice helper.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;

  // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// One storage bank: a single write port shared by all banks and one
// registered read port. The read register can be forced to an alternate
// value (zero register, same-cycle forwarding) chosen by the top level.
module regfile_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_force,
  input  logic [DATA_W-1:0] rd_alt,
  output logic [DATA_W-1:0] q_p1
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents are not reset, the clear sequencer zeroes them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read (stage p1); the array read sees pre-write contents.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)  q_p1 <= '0;
    else if (re)  q_p1 <= rd_force ? rd_alt : mem[raddr];
  end

endmodule

// File: rtl/reg_file_multiport.sv
// Multi-port register file: one write port, NUM_RD registered read ports,
// built-in clear sequencer that zeroes the array after reset and on clr_req.
// Optional macro REGFILE_BYPASS_EN: a read of the address being written in
// the same cycle returns the new data (per port); otherwise old data.
module reg_file_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     aclr_n,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     wren,
  input  logic [ADDR_W-1:0]        wraddress,
  input  logic [DATA_W-1:0]        data,
  output logic                     wr_err,
  input  logic [NUM_RD-1:0]        rden,
  input  logic [NUM_RD*ADDR_W-1:0] rdaddress,
  output logic [NUM_RD*DATA_W-1:0] q
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              run;
  logic              usr_we;
  logic              wr_zero;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;

  assign run     = (state == RUN);
  // A user write is accepted only in RUN and not in a clear-request cycle.
  assign usr_we  = run && wren && !clr_req;
  assign wr_zero = (ZERO_REG != 0) && (wraddress == '0);

  // Sequencer owns the write port in INIT, the user owns it in RUN.
  assign bank_we    = run ? (usr_we && !wr_zero) : 1'b1;
  assign bank_waddr = run ? wraddress : clr_cnt;
  assign bank_wdata = run ? data : '0;

  // Controller: clear sweep in INIT, clear request in RUN, dropped-write flag.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state   <= INIT;
      clr_cnt <= '0;
      ready   <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wren && (!run || clr_req);
      if (!run) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST_ADDR) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end else if (clr_req) begin
        state   <= INIT;
        ready   <= 1'b0;
        clr_cnt <= '0;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              rd_zero;
    logic              rd_force;
    logic [DATA_W-1:0] rd_alt;
    logic [DATA_W-1:0] q_bank;

    assign ra      = rdaddress[slice_lo(i, ADDR_W) +: ADDR_W];
    assign rd_zero = (ZERO_REG != 0) && (ra == '0);

`ifdef REGFILE_BYPASS_EN
    assign rd_force = rd_zero || (usr_we && (ra == wraddress));
    assign rd_alt   = rd_zero ? '0 : data;
`else
    assign rd_force = rd_zero;
    assign rd_alt   = '0;
`endif

    regfile_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk      (clk),
      .aclr_n   (aclr_n),
      .we       (bank_we),
      .waddr    (bank_waddr),
      .wdata    (bank_wdata),
      .re       (run && rden[i]),
      .raddr    (ra),
      .rd_force (rd_force),
      .rd_alt   (rd_alt),
      .q_p1     (q_bank)
    );

    assign q[slice_lo(i, DATA_W) +: DATA_W] = q_bank;
  end

endmodule
